// File: rtl/adder_share_sched_if.sv
// Request/response bundle for adder_share_sched: two operand request ports
// and one valid/ready result port, all sized from WORDS.
interface adder_share_sched_if #(
    parameter int WORDS = 4
);
    localparam int W = 8 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout
    );
endinterface

// File: rtl/adder_share_sched.sv
// Byte-serial multi-precision adder shared between two round-robin requesters;
// one 8-bit ripple-carry slice processes operands LSB byte first.
module ripple_carry_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int unsigned i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[8];
endmodule

module adder_share_sched #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    adder_share_sched_if.slave  bus,
    output logic                busy
);
    localparam int W  = 8 * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          cout_q, cout_d;

    logic          grant0, grant1, rdy0, rdy1;
    logic [7:0]    slice_sum;
    logic          slice_cout;

    ripple_carry_adder u_slice (
        .a_i    (a_q[7:0]),
        .b_i    (b_q[7:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // last_q==1 means requester 1 won last, so requester 0 wins a tie
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign rdy0   = (state_q == IDLE) & grant0 & ~rst;
    assign rdy1   = (state_q == IDLE) & grant1 & ~rst;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = cout_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        last_d  = last_q;
        id_d    = id_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (rdy0 | rdy1) begin
                    id_d    = rdy1;
                    last_d  = rdy1;
                    a_d     = rdy1 ? bus.req1_a   : bus.req0_a;
                    b_d     = rdy1 ? bus.req1_b   : bus.req0_b;
                    carry_d = rdy1 ? bus.req1_cin : bus.req0_cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[8*k_q +: 8] = slice_sum;
                carry_d = slice_cout;
                a_d     = a_q >> 8;
                b_d     = b_q >> 8;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            id_q    <= id_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched (WORDS=4 and WORDS=1 instances)
// against a plain-arithmetic reference with a round-robin winner model.
module tb_adder_share_sched;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy, busy1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   last_grant = 1;

    adder_share_sched_if #(.WORDS(WORDS)) bus ();
    adder_share_sched_if #(.WORDS(1))     bus1 ();

    adder_share_sched #(.WORDS(WORDS)) dut  (.clk(clk), .rst(rst), .bus(bus.slave),  .busy(busy));
    adder_share_sched #(.WORDS(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        if (i == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
        end
    endtask

    function automatic int model_pick(input bit v0, input bit v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        return (last_grant == 1) ? 0 : 1;
    endfunction

    // Inputs already driven in IDLE; checks readies, passes the accept edge.
    task automatic accept(input bit v0, input bit v1, output int who);
        who = model_pick(v0, v1);
        @(negedge clk);
        chk("ready0", bus.req0_ready, (who == 0));
        chk("ready1", bus.req1_ready, (who == 1));
        last_grant = who;
        tick();
        if (who == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [32:0] exp_total, input int exp_id, input int pct);
        bit seen = 0;
        bit done = 0;
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            bus.resp_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (bus.resp_valid && !seen) begin
                seen = 1;
                chk("latency", cyc, WORDS + 1);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                chk("sum",  bus.resp_sum,  exp_total[31:0]);
                chk("cout", bus.resp_cout, exp_total[32]);
                chk("id",   bus.resp_id,   exp_id[0]);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b0;
        if (!done) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        int who;
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic        rc [2];
        bit          pend [2];

        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
        bus.resp_ready = 0;
        bus1.req0_valid = 0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_cin = 0;
        bus1.req1_valid = 0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_cin = 0;
        bus1.resp_ready = 0;

        // reset state, with a request pending that must not see ready
        tick(); tick();
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_valid",  bus.resp_valid, 0);
        chk("rst_sum",    bus.resp_sum,   0);
        chk("rst_cout",   bus.resp_cout,  0);
        chk("rst_id",     bus.resp_id,    0);
        chk("rst_busy",   busy,           0);
        chk("rst_busy1",  busy1,          0);
        chk("rst_valid1", bus1.resp_valid, 0);
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        // req0 alone, full carry ripple
        drive(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        accept(1, 0, who);
        finish_op(33'h1_0000_0000, 0, 100);

        // tie straight after reset: req0 first, req1 at the edge after handshake
        rst = 1'b1; tick(); rst = 1'b0; last_grant = 1;
        drive(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        drive(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        accept(1, 1, who);
        chk("tie_first", who, 0);
        finish_op(33'h0_2345_678A, 0, 100);
        accept(0, 1, who);
        finish_op(33'h1_0000_0000, 1, 100);

        // both continuously valid: grants alternate 0,1,0,1
        drive(0, 32'd10, 32'd20, 1'b0);
        drive(1, 32'd30, 32'd40, 1'b1);
        for (int i = 0; i < 4; i++) begin
            accept(1, 1, who);
            chk("alternate", who, i % 2);
            if (who == 0) begin
                finish_op(33'd30, 0, 100);
                drive(0, 32'd10, 32'd20, 1'b0);
            end else begin
                finish_op(33'd71, 1, 100);
                drive(1, 32'd30, 32'd40, 1'b1);
            end
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();

        // backpressure: result held 10 cycles, no readies while in DONE
        drive(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        accept(1, 0, who);
        drive(0, 32'h5, 32'h6, 1'b0);
        drive(1, 32'h7, 32'h8, 1'b0);
        for (int c = 0; c < 20 && !bus.resp_valid; c++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",  bus.resp_valid, 1);
            chk("bp_sum",    bus.resp_sum,   32'h0000_0100);
            chk("bp_cout",   bus.resp_cout,  0);
            chk("bp_busy",   busy,           1);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_drop_valid", bus.resp_valid, 0);
        chk("bp_drop_busy",  busy,           0);
        tick();

        // reset at k=2 drops the operation
        drive(0, 32'h0102_0304, 32'h1111_1111, 1'b1);
        accept(1, 0, who);
        tick(); tick();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("midrst_ready0", bus.req0_ready, 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        last_grant = 1;
        @(negedge clk);
        chk("midrst_valid", bus.resp_valid, 0);
        chk("midrst_sum",   bus.resp_sum,   0);
        chk("midrst_cout",  bus.resp_cout,  0);
        chk("midrst_id",    bus.resp_id,    0);
        chk("midrst_busy",  busy,           0);
        tick();
        drive(1, 32'h1, 32'h1, 1'b0);
        accept(0, 1, who);
        finish_op(33'd2, 1, 100);

        // WORDS=1 instance: latency 2
        bus1.req0_valid = 1; bus1.req0_a = 8'hFF; bus1.req0_b = 8'h00; bus1.req0_cin = 1;
        bus1.resp_ready = 1;
        @(negedge clk);
        chk("w1_ready0", bus1.req0_ready, 1);
        tick();
        bus1.req0_valid = 0;
        @(negedge clk);
        chk("w1_valid_early", bus1.resp_valid, 0);
        tick();
        @(negedge clk);
        chk("w1_valid", bus1.resp_valid, 1);
        chk("w1_sum",   bus1.resp_sum,   8'h00);
        chk("w1_cout",  bus1.resp_cout,  1);
        chk("w1_id",    bus1.resp_id,    0);
        tick();
        @(negedge clk);
        chk("w1_done", bus1.resp_valid, 0);
        bus1.resp_ready = 0;
        tick();

        // random operations with random contention and resp_ready
        pend[0] = 0; pend[1] = 0;
        for (int op = 0; op < 1000; op++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) != 0) begin
                    pend[i] = 1;
                    ra[i] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    rb[i] = $urandom;
                    rc[i] = $urandom_range(1);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1; ra[0] = $urandom; rb[0] = $urandom; rc[0] = $urandom_range(1);
            end
            for (int i = 0; i < 2; i++) if (pend[i]) drive(i, ra[i], rb[i], rc[i]);
            accept(pend[0], pend[1], who);
            pend[who] = 0;
            finish_op({1'b0, ra[who]} + {1'b0, rb[who]} + {32'b0, rc[who]}, who, 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
